palette_loader: RTL and testbench

//  Sequencer that refills the 16-entry RGB565 colour palette from a table in SDRAM without CPU copying.

---
 rtl/palette_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_palette_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_loader.sv
// palette_loader: refills the 16-entry RGB565 palette from a table in SDRAM.
// An Avalon-MM read master fetches entries FIRST..LAST from BASE. Each returned
// entry is written to the palette port one cycle after its response. A load
// starts either at once (START) or on the next vsync pulse after ARM, so the
// palette can be swapped during vblank without tearing.
module palette_loader #(
  parameter int ADDR_W          = 24,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_csr_address,
  input  logic              avs_csr_write,
  input  logic [31:0]       avs_csr_writedata,
  input  logic              avs_csr_read,
  output logic [31:0]       avs_csr_readdata,
  input  logic              vsync,
  output logic              avm_master_read,
  output logic [ADDR_W-1:0] avm_master_address,
  input  logic [15:0]       avm_master_readdata,
  input  logic              avm_master_readdatavalid,
  input  logic              avm_master_waitrequest,
  output logic [3:0]        avm_palette_address,
  output logic [15:0]       avm_palette_writedata,
  output logic              avm_palette_write,
  output logic              irq
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;

  // CSR-visible configuration and status
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        range_first;
  logic [3:0]        range_last;
  logic              irq_en;
  logic              done_flag;
  logic              err_flag;

  // Per-load shadow copies and progress counters
  logic [3:0]        first_sh;
  logic [4:0]        n_sh;
  logic [4:0]        issued;
  logic [4:0]        resp_cnt;
  logic [3:0]        outstanding;
  logic              aborting;

  // CSR decode
  logic wr_ctrl, wr_base, wr_status, wr_range;
  logic start_req, arm_req, abort_req, err_set;
  logic unused_wdata;

  assign wr_ctrl   = avs_csr_write && (avs_csr_address == 2'd0);
  assign wr_base   = avs_csr_write && (avs_csr_address == 2'd1);
  assign wr_status = avs_csr_write && (avs_csr_address == 2'd2);
  assign wr_range  = avs_csr_write && (avs_csr_address == 2'd3);

  assign start_req = wr_ctrl && avs_csr_writedata[0];
  assign arm_req   = wr_ctrl && avs_csr_writedata[1];
  assign abort_req = wr_ctrl && avs_csr_writedata[3];

  // Only a subset of the write data bits is meaningful for any register.
  assign unused_wdata = ^avs_csr_writedata;

  // Load control terms
  logic       busy, armed, in_load;
  logic       accept, resp, stopping, launch;
  logic [3:0] outstanding_nxt;
  logic [4:0] issued_nxt;
  logic [4:0] n_cfg;
  logic       more_to_issue, room, read_nxt;

  assign busy    = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_DONE);
  assign armed   = (state == S_ARMED);
  assign in_load = (state == S_ISSUE) || (state == S_DRAIN);

  // Wrap through 15->0 falls out of the 4-bit subtraction.
  assign n_cfg = {1'b0, range_last - range_first} + 5'd1;

  assign accept = avm_master_read && !avm_master_waitrequest;
  // Responses outside a load (e.g. stale ones after reset) are dropped.
  assign resp   = avm_master_readdatavalid && in_load && (outstanding != 4'd0);

  // Same-cycle accept and response cancel out in the outstanding count.
  assign outstanding_nxt = outstanding + 4'(accept) - 4'(resp);
  assign issued_nxt      = issued + 5'(accept);
  assign more_to_issue   = issued_nxt < n_sh;
  assign room            = outstanding_nxt < MAX_OUT;

  // Abort takes effect in the cycle of the ABORT write itself.
  assign stopping = in_load && (aborting || abort_req);

  // A request stalled by waitrequest must stay up until accepted, even on abort.
  assign read_nxt = stopping ? (avm_master_read && avm_master_waitrequest)
                             : ((state == S_ISSUE) && more_to_issue && room);

  assign launch = ((state == S_IDLE) && start_req) ||
                  ((state == S_ARMED) && vsync && !abort_req);

  assign err_set = (start_req || arm_req) && (state != S_IDLE);

  assign irq = done_flag && irq_en;

  // CSR registers: configuration writes, sticky/W1C status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_addr   <= '0;
      range_first <= 4'h0;
      range_last  <= 4'hF;
      irq_en      <= 1'b0;
      done_flag   <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= avs_csr_writedata[2];
      if (wr_base) base_addr <= {avs_csr_writedata[ADDR_W-1:1], 1'b0};
      if (wr_range) begin
        range_first <= avs_csr_writedata[3:0];
        range_last  <= avs_csr_writedata[11:8];
      end
      if (wr_status && avs_csr_writedata[2]) done_flag <= 1'b0;
      if (state == S_DONE) done_flag <= 1'b1;
      if (wr_status && avs_csr_writedata[3]) err_flag <= 1'b0;
      if (err_set) err_flag <= 1'b1;
    end
  end

  // Load sequencer: start/arm, request issue with flow control, drain, abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      avm_master_read    <= 1'b0;
      avm_master_address <= '0;
      first_sh           <= 4'h0;
      n_sh               <= 5'd0;
      issued             <= 5'd0;
      resp_cnt           <= 5'd0;
      outstanding        <= 4'd0;
      aborting           <= 1'b0;
    end else if (launch) begin
      state              <= S_ISSUE;
      avm_master_read    <= 1'b1;
      avm_master_address <= base_addr;
      first_sh           <= range_first;
      n_sh               <= n_cfg;
      issued             <= 5'd0;
      resp_cnt           <= 5'd0;
      outstanding        <= 4'd0;
      aborting           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm_req) state <= S_ARMED;
        end
        S_ARMED: begin
          if (abort_req) state <= S_IDLE;
        end
        S_ISSUE, S_DRAIN: begin
          avm_master_read <= read_nxt;
          outstanding     <= outstanding_nxt;
          issued          <= issued_nxt;
          if (accept) avm_master_address <= avm_master_address + ADDR_W'(2);
          if (resp && !stopping) resp_cnt <= resp_cnt + 5'd1;
          if (abort_req) aborting <= 1'b1;
          if (stopping) begin
            if (!read_nxt && (outstanding_nxt == 4'd0)) begin
              state    <= S_IDLE;
              aborting <= 1'b0;
            end
          end else if ((state == S_ISSUE) && accept && !more_to_issue) begin
            state <= S_DRAIN;
          end else if ((state == S_DRAIN) && resp && ((resp_cnt + 5'd1) == n_sh)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Palette write port: one registered write per accepted response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm_palette_write     <= 1'b0;
      avm_palette_address   <= 4'h0;
      avm_palette_writedata <= 16'h0;
    end else begin
      avm_palette_write <= resp && !stopping;
      if (resp && !stopping) begin
        avm_palette_address   <= first_sh + resp_cnt[3:0];
        avm_palette_writedata <= avm_master_readdata;
      end
    end
  end

  // CSR read mux
  logic [31:0] csr_mux;

  always_comb begin
    csr_mux = '0;
    case (avs_csr_address)
      2'd0: csr_mux[2] = irq_en;
      2'd1: csr_mux = 32'(base_addr);
      2'd2: csr_mux[3:0] = {err_flag, done_flag, armed, busy};
      2'd3: begin
        csr_mux[3:0]  = range_first;
        csr_mux[11:8] = range_last;
      end
      default: csr_mux = '0;
    endcase
  end

  // CSR read data register, updated one cycle after each read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_csr_readdata <= '0;
    end else if (avs_csr_read) begin
      avs_csr_readdata <= csr_mux;
    end
  end

endmodule

// File: tb/tb_palette_loader.sv
// Directed testbench for palette_loader with a latency-configurable
// in-order Avalon-MM memory model and a palette write recorder.
module tb_palette_loader;

  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        avs_csr_address = 2'd0;
  logic              avs_csr_write = 1'b0;
  logic [31:0]       avs_csr_writedata = 32'd0;
  logic              avs_csr_read = 1'b0;
  logic [31:0]       avs_csr_readdata;
  logic              vsync = 1'b0;
  logic              avm_master_read;
  logic [ADDR_W-1:0] avm_master_address;
  logic [15:0]       avm_master_readdata = 16'h0;
  logic              avm_master_readdatavalid = 1'b0;
  logic              avm_master_waitrequest = 1'b0;
  logic [3:0]        avm_palette_address;
  logic [15:0]       avm_palette_writedata;
  logic              avm_palette_write;
  logic              irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  palette_loader #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(4)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .avs_csr_address          (avs_csr_address),
    .avs_csr_write            (avs_csr_write),
    .avs_csr_writedata        (avs_csr_writedata),
    .avs_csr_read             (avs_csr_read),
    .avs_csr_readdata         (avs_csr_readdata),
    .vsync                    (vsync),
    .avm_master_read          (avm_master_read),
    .avm_master_address       (avm_master_address),
    .avm_master_readdata      (avm_master_readdata),
    .avm_master_readdatavalid (avm_master_readdatavalid),
    .avm_master_waitrequest   (avm_master_waitrequest),
    .avm_palette_address      (avm_palette_address),
    .avm_palette_writedata    (avm_palette_writedata),
    .avm_palette_write        (avm_palette_write),
    .irq                      (irq)
  );

  // Memory contents: entry at byte address a holds 0xF000 + a[16:1]
  function automatic logic [15:0] exp_data(input logic [ADDR_W-1:0] a);
    return 16'hF000 + a[16:1];
  endfunction

  // Memory model and recorders
  int lat = 3;
  int wait_idx = -1;
  int wait_len = 0;
  int req_idx = 0;
  int ncyc = 0;
  int outst = 0;
  int max_out = 0;
  int hold_cycles = 0;
  logic held = 1'b0;
  logic [ADDR_W-1:0] held_addr = '0;
  logic [ADDR_W-1:0] pend_addr[$];
  int                pend_due[$];
  logic [ADDR_W-1:0] acc_q[$];
  logic [3:0]        pw_idx[$];
  logic [15:0]       pw_data[$];

  always @(negedge clk) begin
    ncyc++;
    if (avm_palette_write === 1'b1) begin
      pw_idx.push_back(avm_palette_address);
      pw_data.push_back(avm_palette_writedata);
    end
    if (held) begin
      checks++;
      assert (avm_master_read === 1'b1 && avm_master_address === held_addr)
        else begin
          errors++;
          $error("FAIL hold: read=%b addr=0x%0h required read=1 addr=0x%0h",
                 avm_master_read, avm_master_address, held_addr);
        end
    end
    avm_master_readdatavalid = 1'b0;
    avm_master_readdata = 16'h0;
    if (pend_addr.size() > 0 && pend_due[0] <= ncyc) begin
      avm_master_readdatavalid = 1'b1;
      avm_master_readdata = exp_data(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      outst--;
    end
    avm_master_waitrequest = (avm_master_read === 1'b1) && (req_idx == wait_idx) && (wait_len > 0);
    if (avm_master_waitrequest) begin
      wait_len--;
      hold_cycles++;
    end
    held = avm_master_waitrequest;
    held_addr = avm_master_address;
    if (avm_master_read === 1'b1 && !avm_master_waitrequest) begin
      pend_addr.push_back(avm_master_address);
      pend_due.push_back(ncyc + lat);
      acc_q.push_back(avm_master_address);
      req_idx++;
      outst++;
      if (outst > max_out) max_out = outst;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_csr_address = a;
    avs_csr_writedata = d;
    avs_csr_write = 1'b1;
    @(negedge clk);
    avs_csr_write = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_csr_address = a;
    avs_csr_read = 1'b1;
    @(negedge clk);
    avs_csr_read = 1'b0;
    d = avs_csr_readdata;
  endtask

  task automatic clear_logs();
    @(posedge clk);
    acc_q.delete();
    pw_idx.delete();
    pw_data.delete();
    req_idx = 0;
    max_out = 0;
    hold_cycles = 0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      csr_read(2'd2, d);
      if (d[1:0] == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, {31'd0, ok}, 32'd1);
  endtask

  // Compares recorded requests and palette writes with the expected load
  task automatic check_load(input string tag, input logic [ADDR_W-1:0] base,
                            input logic [3:0] first, input int n);
    logic [ADDR_W-1:0] a;
    logic [3:0] idx;
    check({tag, "_nreq"}, acc_q.size(), n);
    check({tag, "_nwr"}, pw_idx.size(), n);
    for (int k = 0; k < n; k++) begin
      a = base + ADDR_W'(2 * k);
      idx = first + 4'(k);
      if (k < acc_q.size())
        check($sformatf("%s_addr%0d", tag, k), 32'(acc_q[k]), 32'(a));
      if (k < pw_idx.size()) begin
        check($sformatf("%s_idx%0d", tag, k), 32'(pw_idx[k]), 32'(idx));
        check($sformatf("%s_data%0d", tag, k), 32'(pw_data[k]), 32'(exp_data(a)));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int seen;
    int nw;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_read", 32'(avm_master_read), 32'd0);
    check("rst_pwrite", 32'(avm_palette_write), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_addr", 32'(avm_master_address), 32'd0);
    csr_read(2'd0, d); check("rst_ctrl", d, 32'h0);
    csr_read(2'd1, d); check("rst_base", d, 32'h0);
    csr_read(2'd2, d); check("rst_status", d, 32'h0);
    csr_read(2'd3, d); check("rst_range", d, 32'h0F00);

    // Full 16-entry load, latency 3, IRQ enabled
    lat = 3;
    csr_write(2'd1, 32'h0000_1001);
    csr_read(2'd1, d); check("t1_base_b0", d, 32'h1000);
    csr_write(2'd0, 32'h4);
    csr_read(2'd0, d); check("t1_ctrl_irqen", d, 32'h4);
    clear_logs();
    csr_write(2'd0, 32'h5);
    wait_idle("t1");
    check_load("t1", 24'h1000, 4'd0, 16);
    csr_read(2'd2, d); check("t1_status", d, 32'h4);
    check("t1_irq", 32'(irq), 32'd1);
    csr_write(2'd2, 32'h4);
    csr_read(2'd2, d); check("t1_status_w1c", d, 32'h0);
    check("t1_irq_clr", 32'(irq), 32'd0);

    // Wrapping range FIRST=14 LAST=1
    csr_write(2'd3, 32'h0000_010E);
    clear_logs();
    csr_write(2'd0, 32'h5);
    wait_idle("t2");
    check_load("t2", 24'h1000, 4'd14, 4);
    csr_write(2'd2, 32'h4);

    // Waitrequest on request 2 for 5 cycles, latency 10
    csr_write(2'd3, 32'h0000_0F00);
    csr_write(2'd1, 32'h0000_2000);
    lat = 10;
    clear_logs();
    wait_idx = 2;
    wait_len = 5;
    csr_write(2'd0, 32'h5);
    wait_idle("t3");
    check_load("t3", 24'h2000, 4'd0, 16);
    check("t3_hold_cycles", hold_cycles, 32'd5);
    check("t3_max_out_le4", {31'd0, (max_out <= 4)}, 32'd1);
    check("t3_max_out_reached", max_out, 32'd4);
    wait_idx = -1;
    csr_write(2'd2, 32'h4);

    // ARM coinciding with vsync is ignored; next vsync starts the load
    csr_write(2'd1, 32'h0000_1000);
    lat = 4;
    clear_logs();
    @(negedge clk);
    avs_csr_address = 2'd0;
    avs_csr_writedata = 32'h6;
    avs_csr_write = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    avs_csr_write = 1'b0;
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    csr_read(2'd2, d); check("t4_armed", d, 32'h2);
    check("t4_no_req", acc_q.size(), 32'd0);
    @(negedge clk);
    vsync = 1'b1;
    check("t4_read_before_vsync", 32'(avm_master_read), 32'd0);
    @(negedge clk);
    vsync = 1'b0;
    check("t4_read_after_vsync", 32'(avm_master_read), 32'd1);
    csr_write(2'd0, 32'h5);
    csr_read(2'd2, d); check("t4_busy_err", d, 32'h9);
    wait_idle("t4");
    check_load("t4", 24'h1000, 4'd0, 16);
    csr_read(2'd2, d); check("t4_status_done", d, 32'hC);
    check("t4_irq", 32'(irq), 32'd1);
    csr_write(2'd2, 32'hC);
    csr_read(2'd2, d); check("t4_status_clr", d, 32'h0);

    // ABORT after 3 palette writes; remaining responses discarded
    csr_write(2'd1, 32'h0000_3000);
    lat = 6;
    clear_logs();
    csr_write(2'd0, 32'h1);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (avm_palette_write === 1'b1) seen++;
      if (seen == 3) break;
    end
    check("t5_seen3", seen, 32'd3);
    avs_csr_address = 2'd0;
    avs_csr_writedata = 32'h8;
    avs_csr_write = 1'b1;
    @(negedge clk);
    avs_csr_write = 1'b0;
    wait_idle("t5");
    #1;
    check("t5_pend_empty", pend_addr.size(), 32'd0);
    check("t5_nwr", pw_idx.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < pw_idx.size()) begin
        check($sformatf("t5_idx%0d", k), 32'(pw_idx[k]), k);
        check($sformatf("t5_data%0d", k), 32'(pw_data[k]), 32'(exp_data(24'h3000 + ADDR_W'(2 * k))));
      end
    end
    repeat (10) @(negedge clk);
    check("t5_nwr_late", pw_idx.size(), 32'd3);
    csr_read(2'd2, d); check("t5_status", d, 32'h0);
    check("t5_irq", 32'(irq), 32'd0);

    // Reset during DRAIN, then stale responses
    csr_write(2'd1, 32'h0000_1000);
    csr_write(2'd3, 32'h0000_0300);
    lat = 8;
    clear_logs();
    csr_write(2'd0, 32'h5);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (avm_palette_write === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("t6_first_write", seen, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_read", 32'(avm_master_read), 32'd0);
    check("t6_addr", 32'(avm_master_address), 32'd0);
    check("t6_pwrite", 32'(avm_palette_write), 32'd0);
    check("t6_paddr", 32'(avm_palette_address), 32'd0);
    check("t6_pdata", 32'(avm_palette_writedata), 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    check("t6_rdata", avs_csr_readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nw = pw_idx.size();
    repeat (20) @(negedge clk);
    #1;
    check("t6_stale_pend_empty", pend_addr.size(), 32'd0);
    check("t6_no_stale_write", pw_idx.size(), nw);
    csr_read(2'd2, d); check("t6_status", d, 32'h0);
    csr_read(2'd3, d); check("t6_range", d, 32'h0F00);
    csr_read(2'd1, d); check("t6_base", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
